mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous word memory between the instruction-fetch requester (PC/IM side) and the data requester (load/store side) of the multi-cycle MIPS core.
- Does round-robin arbitration and sequences each access as issue → response, with a one-cycle ack pulse per transaction.
- Sits between the core's fetch/memory stages and the unified memory macro, in place of separate IM/DM arrays.

Parameters:
- ADDR_W, 32, byte-address width on both requester ports and the memory port.
- DATA_W, 32, data width; BE_W = DATA_W/8 derived.
- RESET_PRIO_IF, 1, when 1 the fetch port wins the first tie after reset; when 0 the data port wins it.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  DATA_W  fetched word.
- if_err  out  1  valid with if_ack; misaligned address (addr[1:0]!=0).
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  BE_W  byte enables for stores (ignored on loads).
- d_addr  in  ADDR_W  data byte address (word-aligned; byte lanes selected by d_be).
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse; d_rdata is valid in the same cycle for loads.
- d_rdata  out  DATA_W  load word.
- d_err  out  1  valid with d_ack; d_addr[1:0]!=0, or d_be==0 on a store.
- mem_en  out  1  memory access strobe, registered.
- mem_we  out  1  memory write, registered.
- mem_be  out  BE_W  memory byte enables, registered.
- mem_addr  out  ADDR_W-2  word address, registered.
- mem_wdata  out  DATA_W  registered.
- mem_rdata  in  DATA_W  valid one cycle after the mem_en cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: IDLE. if_ack, d_ack, if_err, d_err, mem_en, mem_we and busy are 0; mem_be, mem_addr and mem_wdata are 0. The round-robin pointer takes its RESET_PRIO_IF value.
- Reset mid-transaction: the access is dropped, no ack is issued, and mem_en/mem_we go low on the next edge.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any eligible request is present, grant one, register mem_* from the winner's inputs, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_en=1 for exactly this cycle; mem_we=1 only for a granted store.
  - Always go to RESP.
- RESP:
  - Assert the granted port's ack combinationally from state.
  - The rdata output passes mem_rdata through (loads/fetches). On a store, rdata holds 0.
  - Back-to-back: RESP arbitrates like IDLE. The port being acked is ineligible this cycle (its req is still high). The other port's request is granted and goes to ISSUE; otherwise go to IDLE.
- Latency: req seen in cycle N (IDLE) → mem_en in N+1 → ack in N+2. Sustained alternating traffic gives one transaction per 2 cycles.
- Arbitration:
  - Single request: it wins.
  - Both requesting: the port not granted last wins.
  - The pointer updates on every grant.
- Error handling:
  - An erroring request is granted normally, but mem_en stays 0 in ISSUE (no memory write).
  - ack pulses in RESP with err=1 and rdata=0.
- req dropped before ack: the transaction still completes and the ack still pulses; the requester ignores it.
- Inputs are sampled only at grant; later changes to addr/wdata have no effect.
- mem_addr = granted addr[ADDR_W-1:2].
- Widths are exact, with no sign extension. Load lane extraction is the requester's job.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), the port-ID constants PORT_IF/PORT_D, and Word/width macros consistent with the existing header.
- One sub-module, rr_arb2: a 2-input round-robin arbiter with a registered last-grant pointer and an eligibility mask input. It is reusable for future shared resources.

Test Plan:
- Reset, then if_req with if_addr=0x3000, mem word 0x3000 = 0x2408_0005 → mem_en in cycle 2, mem_addr=0xC00, if_ack in cycle 3 with if_rdata=0x2408_0005 and if_err=0.
- Store d_we=1, d_addr=0x10, d_be=4'b0011, d_wdata=0xAABBCCDD → one mem_we cycle with mem_be=0011. A subsequent load of 0x10 returns the upper bytes unchanged and the lower 16 bits =0xCCDD.
- if_req and d_req both held high for 8 cycles after reset with RESET_PRIO_IF=1 → grants IF,D,IF,D; acks every 2 cycles; no port acked twice in a row.
- d_addr=0x13 load → no mem_en pulse, d_ack with d_err=1 and d_rdata=0. Store with d_be=0 → no mem_we, d_err=1.
- reset asserted in the ISSUE cycle of a store → mem_we low the next cycle, no d_ack, state IDLE; the memory word is unchanged if reset precedes the write edge.
- if_req dropped one cycle after grant → if_ack still pulses at N+2. A following d_req is granted directly from RESP with no IDLE bubble.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding, port IDs and word geometry
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D = 1'b1;
    localparam int WORD_W = 32;
    localparam int ADDR_LSB = 2;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with eligibility mask and registered last-grant pointer
module rr_arb2 #(
    parameter logic RESET_LAST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic       valid,
    output logic       id
);
    logic       last;
    logic [1:0] elig;
    always_comb begin
        elig = req & mask;
        valid = |elig;
        id = &elig ? ~last : elig[1];
    end
    always_ff @(posedge clk) begin
        if (reset)
            last <= RESET_LAST;
        else if (en && valid)
            last <= id;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous word memory between fetch and data requesters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = WORD_W,
    parameter int RESET_PRIO_IF = 1,
    localparam int BE_W = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_req,
    input  logic [ADDR_W-1:0]        if_addr,
    output logic                     if_ack,
    output logic [DATA_W-1:0]        if_rdata,
    output logic                     if_err,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [BE_W-1:0]          d_be,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic [DATA_W-1:0]        d_wdata,
    output logic                     d_ack,
    output logic [DATA_W-1:0]        d_rdata,
    output logic                     d_err,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [BE_W-1:0]          mem_be,
    output logic [ADDR_W-ADDR_LSB-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy
);
    state_t     state;
    state_t     state_n;
    logic       gnt_port;
    logic       gnt_err;
    logic       gnt_we;
    logic       arb_en;
    logic [1:0] arb_req;
    logic [1:0] arb_mask;
    logic       win_valid;
    logic       win_id;
    logic       win_we;
    logic       win_err;
    logic       rd_ok;

    rr_arb2 #(.RESET_LAST(RESET_PRIO_IF != 0)) u_arb (
        .clk(clk),
        .reset(reset),
        .en(arb_en),
        .req(arb_req),
        .mask(arb_mask),
        .valid(win_valid),
        .id(win_id)
    );

    always_comb begin
        arb_en = state != ISSUE;
        arb_req = {d_req, if_req};
        arb_mask = state == RESP ? (gnt_port == PORT_D ? 2'b01 : 2'b10) : 2'b11;
        win_we = win_id == PORT_D && d_we;
        win_err = win_id == PORT_D ? (d_addr[1:0] != 2'b00 || (d_we && d_be == '0)) : if_addr[1:0] != 2'b00;
        state_n = state == ISSUE ? RESP : win_valid ? ISSUE : IDLE;
        rd_ok = !gnt_err && !gnt_we;
        if_ack = state == RESP && gnt_port == PORT_IF;
        d_ack = state == RESP && gnt_port == PORT_D;
        if_err = if_ack && gnt_err;
        d_err = d_ack && gnt_err;
        if_rdata = if_ack && rd_ok ? mem_rdata : '0;
        d_rdata = d_ack && rd_ok ? mem_rdata : '0;
        busy = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt_port <= PORT_IF;
            gnt_err <= 1'b0;
            gnt_we <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_n;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (arb_en && win_valid) begin
                gnt_port <= win_id;
                gnt_err <= win_err;
                gnt_we <= win_we;
                mem_en <= !win_err;
                mem_we <= win_we && !win_err;
                mem_be <= win_we ? d_be : '1;
                mem_addr <= win_id == PORT_D ? d_addr[ADDR_W-1:ADDR_LSB] : if_addr[ADDR_W-1:ADDR_LSB];
                mem_wdata <= win_we ? d_wdata : '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the shared memory port arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    logic [31:0] mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RESET_PRIO_IF(1)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr[11:0]];
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[11:0]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        tick();
        tick();
        n_vec++;
        if ({if_ack, d_ack, if_err, d_err, mem_en, mem_we, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 0000000", {if_ack, d_ack, if_err, d_err, mem_en, mem_we, busy});
        end
        n_vec++;
        if (mem_be !== 4'h0) begin n_err++; $display("FAIL reset_mem_be: got %h expected 0", mem_be); end
        n_vec++;
        if (mem_addr !== 30'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        n_vec++;
        if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        reset = 0;
        tick();
    endtask

    task automatic test_fetch();
        mem[12'hC00] = 32'h2408_0005;
        ref_mem[12'hC00] = 32'h2408_0005;
        if_addr = 32'h3000;
        if_req = 1;
        tick();
        n_vec++;
        if ({mem_en, mem_we, mem_addr, if_ack} !== {1'b1, 1'b0, 30'hC00, 1'b0}) begin
            n_err++;
            $display("FAIL fetch_issue: got en=%b we=%b addr=%h ack=%b expected en=1 we=0 addr=c00 ack=0", mem_en, mem_we, mem_addr, if_ack);
        end
        tick();
        n_vec++;
        if ({if_ack, if_err, if_rdata} !== {1'b1, 1'b0, 32'h2408_0005}) begin
            n_err++;
            $display("FAIL fetch_resp: got ack=%b err=%b rdata=%h expected ack=1 err=0 rdata=24080005", if_ack, if_err, if_rdata);
        end
        if_req = 0;
        tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL fetch_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_store_load();
        logic [31:0] exp;
        exp = {ref_mem[4][31:16], 16'hCCDD};
        d_req = 1; d_we = 1; d_addr = 32'h10; d_be = 4'b0011; d_wdata = 32'hAABBCCDD;
        tick();
        n_vec++;
        if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 30'h4, 32'hAABBCCDD}) begin
            n_err++;
            $display("FAIL store_issue: got en=%b we=%b be=%b addr=%h wd=%h expected en=1 we=1 be=0011 addr=4 wd=aabbccdd", mem_en, mem_we, mem_be, mem_addr, mem_wdata);
        end
        tick();
        n_vec++;
        if ({d_ack, d_err, d_rdata, mem_we} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL store_resp: got ack=%b err=%b rdata=%h we=%b expected ack=1 err=0 rdata=0 we=0", d_ack, d_err, d_rdata, mem_we);
        end
        ref_mem[4] = exp;
        d_req = 0;
        tick();
        d_req = 1; d_we = 0; d_be = 4'b0000; d_wdata = 32'h1234_5678;
        tick();
        tick();
        n_vec++;
        if ({d_ack, d_err, d_rdata} !== {1'b1, 1'b0, exp}) begin
            n_err++;
            $display("FAIL load_after_store: got ack=%b err=%b rdata=%h expected ack=1 err=0 rdata=%h", d_ack, d_err, d_rdata, exp);
        end
        d_req = 0;
        tick();
    endtask

    task automatic test_alternate();
        logic [1:0] got [8];
        logic [1:0] want;
        reset = 1;
        idle_inputs();
        tick();
        reset = 0;
        if_addr = 32'h40; d_addr = 32'h44; d_we = 0;
        if_req = 1; d_req = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            got[c-1] = {if_ack, d_ack};
            if (if_ack) begin
                n_vec++;
                if (if_rdata !== ref_mem[16]) begin n_err++; $display("FAIL alt_if_rdata c%0d: got %h expected %h", c, if_rdata, ref_mem[16]); end
            end
            if (d_ack) begin
                n_vec++;
                if (d_rdata !== ref_mem[17]) begin n_err++; $display("FAIL alt_d_rdata c%0d: got %h expected %h", c, d_rdata, ref_mem[17]); end
            end
        end
        if_req = 0; d_req = 0;
        for (int c = 1; c <= 8; c++) begin
            want = (c % 2 == 1) ? 2'b00 : (c % 4 == 2) ? 2'b10 : 2'b01;
            n_vec++;
            if (got[c-1] !== want) begin
                n_err++;
                $display("FAIL alt_ack c%0d: got {if_ack,d_ack}=%b expected %b", c, got[c-1], want);
            end
        end
        tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL alt_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_errors();
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h13;
        tick();
        n_vec++;
        if ({mem_en, busy} !== 2'b01) begin n_err++; $display("FAIL misaligned_issue: got en=%b busy=%b expected en=0 busy=1", mem_en, busy); end
        tick();
        n_vec++;
        if ({d_ack, d_err, d_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL misaligned_resp: got ack=%b err=%b rdata=%h expected ack=1 err=1 rdata=0", d_ack, d_err, d_rdata);
        end
        d_req = 0;
        tick();
        d_req = 1; d_we = 1; d_be = 4'h0; d_addr = 32'h20; d_wdata = $urandom;
        tick();
        n_vec++;
        if ({mem_en, mem_we} !== 2'b00) begin n_err++; $display("FAIL be0_issue: got en=%b we=%b expected 00", mem_en, mem_we); end
        tick();
        n_vec++;
        if ({d_ack, d_err, d_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL be0_resp: got ack=%b err=%b rdata=%h expected ack=1 err=1 rdata=0", d_ack, d_err, d_rdata);
        end
        d_req = 0;
        tick();
        n_vec++;
        if (mem[8] !== ref_mem[8]) begin n_err++; $display("FAIL be0_mem: got %h expected %h", mem[8], ref_mem[8]); end
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h800; d_wdata = 32'hDEAD_BEEF;
        tick();
        n_vec++;
        if (mem_we !== 1'b1) begin n_err++; $display("FAIL rstmid_issue: got we=%b expected 1", mem_we); end
        reset = 1;
        d_req = 0;
        tick();
        n_vec++;
        if ({mem_en, mem_we, busy, d_ack} !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmid_after: got en=%b we=%b busy=%b ack=%b expected 0000", mem_en, mem_we, busy, d_ack);
        end
        reset = 0;
        tick();
        tick();
        n_vec++;
        if ({d_ack, if_ack, busy} !== 3'b000) begin n_err++; $display("FAIL rstmid_quiet: got d_ack=%b if_ack=%b busy=%b expected 000", d_ack, if_ack, busy); end
    endtask

    task automatic test_back_to_back();
        if_addr = 32'h80; if_req = 1;
        tick();
        if_req = 0;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h84;
        tick();
        n_vec++;
        if ({if_ack, if_rdata} !== {1'b1, ref_mem[32]}) begin
            n_err++;
            $display("FAIL drop_if_ack: got ack=%b rdata=%h expected ack=1 rdata=%h", if_ack, if_rdata, ref_mem[32]);
        end
        tick();
        d_addr = 32'h88;
        n_vec++;
        if ({mem_en, mem_addr, busy} !== {1'b1, 30'h21, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_issue: got en=%b addr=%h busy=%b expected en=1 addr=21 busy=1", mem_en, mem_addr, busy);
        end
        tick();
        n_vec++;
        if ({d_ack, d_rdata} !== {1'b1, ref_mem[33]}) begin
            n_err++;
            $display("FAIL b2b_d_ack: got ack=%b rdata=%h expected ack=1 rdata=%h", d_ack, d_rdata, ref_mem[33]);
        end
        d_req = 0;
        tick();
    endtask

    task automatic test_random();
        bit ip = 0;
        bit dp = 0;
        int iage = 0;
        int dage = 0;
        logic [31:0] ia = '0;
        logic [31:0] da = '0;
        logic [31:0] dw = '0;
        logic [3:0]  dbe = '0;
        logic        dwe = 0;
        logic        e_err;
        logic [31:0] e_rd;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (if_ack && d_ack) begin
                n_vec++;
                n_err++;
                $display("FAIL rand_dual_ack cyc%0d: got both acks expected at most one", cyc);
            end
            if (if_ack) begin
                n_vec++;
                e_err = ia[1:0] != 2'b00;
                e_rd = e_err ? 32'h0 : ref_mem[ia[13:2]];
                if (!ip || iage > 5 || {if_err, if_rdata} !== {e_err, e_rd}) begin
                    n_err++;
                    $display("FAIL rand_if cyc%0d: got pend=%b age=%0d err=%b rdata=%h expected pend=1 age<=5 err=%b rdata=%h", cyc, ip, iage, if_err, if_rdata, e_err, e_rd);
                end
                ip = 0;
            end
            if (d_ack) begin
                n_vec++;
                e_err = da[1:0] != 2'b00 || (dwe && dbe == 4'h0);
                e_rd = (e_err || dwe) ? 32'h0 : ref_mem[da[13:2]];
                if (!dp || dage > 5 || {d_err, d_rdata} !== {e_err, e_rd}) begin
                    n_err++;
                    $display("FAIL rand_d cyc%0d: got pend=%b age=%0d err=%b rdata=%h expected pend=1 age<=5 err=%b rdata=%h", cyc, dp, dage, d_err, d_rdata, e_err, e_rd);
                end
                if (dwe && !e_err) ref_mem[da[13:2]] = merge(ref_mem[da[13:2]], dbe, dw);
                dp = 0;
            end
            if (cyc < 680) begin
                if (!ip && $urandom_range(0, 2) == 0) begin
                    ip = 1;
                    iage = 0;
                    ia = {20'h0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'b00, ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
                end
                if (!dp && $urandom_range(0, 2) == 0) begin
                    dp = 1;
                    dage = 0;
                    da = {20'h0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'b00, ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
                    dwe = $urandom_range(0, 1) == 1;
                    dbe = 4'($urandom_range(0, 15));
                    dw = $urandom;
                end
            end
            if_req = ip; if_addr = ia;
            d_req = dp; d_addr = da; d_we = dwe; d_be = dbe; d_wdata = dw;
            tick();
            if (ip) iage++;
            if (dp) dage++;
        end
        n_vec++;
        if ({ip, dp} !== 2'b00) begin n_err++; $display("FAIL rand_drain: got pending if=%b d=%b expected none", ip, dp); end
        idle_inputs();
        tick();
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                n_vec++;
                n_err++;
                $display("FAIL rand_mem word%0d: got %h expected %h", i, mem[i], ref_mem[i]);
            end
        end
        n_vec++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_fetch();
        test_store_load();
        test_alternate();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
